// File: rtl/crypto_pkg.sv
// Shared definitions for the block-cipher round controller and its round counter.
package crypto_pkg;

    localparam int DATA_W   = 128;
    localparam int CNT_LAST = 17;
    localparam int RK_LAST  = 16;
    localparam int WD_LIMIT = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/round_ctrl.sv
// Round controller: accepts a block, runs the external round counter through one
// full pass, captures the datapath result and holds it until taken downstream.
module round_ctrl
    import crypto_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dec,
    output logic              start,
    input  logic [4:0]        cnt,
    input  logic              cnt_end,
    output logic              load,
    output logic [DATA_W-1:0] blk_q,
    output logic              round_en,
    output logic [4:0]        rk_idx,
    input  logic [DATA_W-1:0] core_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    state_t     state;
    logic       dec_q;
    logic [4:0] wd;
    logic       accept;

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Rounds run only while the counter has not yet reached its last value.
    assign round_en = start & ~cnt_end;
    assign rk_idx   = !round_en ? 5'd0
                    : (dec_q ? (5'(RK_LAST) - cnt) : cnt);

    // NOTE: state is updated with non-blocking assignments only, so every branch
    // below reads the pre-edge values of state, wd and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            start     <= 1'b0;
            load      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            dec_q     <= 1'b0;
            wd        <= 5'd0;
            // NOTE: the wide data registers are reset too, so nothing stale from an
            // aborted run is ever visible on blk_q or out_data.
            blk_q     <= '0;
            out_data  <= '0;
        end else begin
            load <= 1'b0;
            if (state == S_DONE && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                blk_q <= in_data;
                dec_q <= in_dec;
                load  <= 1'b1;
                start <= 1'b1;
                wd    <= 5'd0;
                state <= S_RUN;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_RUN: begin
                        if (cnt_end) begin
                            out_data  <= core_data;
                            out_valid <= 1'b1;
                            start     <= 1'b0;
                            state     <= S_DONE;
                        end else if (wd == 5'(WD_LIMIT - 1)) begin
                            // Counter never finished: abandon the run, keep err sticky.
                            err   <= 1'b1;
                            start <= 1'b0;
                            wd    <= 5'd0;
                            state <= S_IDLE;
                        end else begin
                            wd <= wd + 5'd1;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with a behavioural round counter and a
// result scoreboard filled at each accept and drained at each output handshake.
module tb_round_ctrl;
    import crypto_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_dec;
    logic              start;
    logic [4:0]        cnt;
    logic              cnt_end;
    logic              load;
    logic [DATA_W-1:0] blk_q;
    logic              round_en;
    logic [4:0]        rk_idx;
    logic [DATA_W-1:0] core_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err;

    logic              no_end;
    logic [31:0]       cyc = 32'd0;
    logic [DATA_W-1:0] exp_blk = '0;

    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] obs_q[$];
    logic [31:0]       acc_q[$];
    logic [31:0]       ov_q[$];
    logic [4:0]        rk_log[$];
    int                start_cnt, load_cnt, low_run, last_gap;
    logic [4:0]        load_cnt_val;
    logic [31:0]       err_cyc;
    bit                err_seen;
    int                n_checks = 0;
    int                n_fail = 0;

    localparam logic [DATA_W-1:0] D_ENC = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [DATA_W-1:0] D_DEC = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;

    round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dec    (in_dec),
        .start     (start),
        .cnt       (cnt),
        .cnt_end   (cnt_end),
        .load      (load),
        .blk_q     (blk_q),
        .round_en  (round_en),
        .rk_idx    (rk_idx),
        .core_data (core_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 32'd1;

    // Behavioural sibling round counter; no_end models a counter that never finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            cnt_end <= 1'b0;
        end else if (!start) begin
            cnt     <= 5'd0;
            cnt_end <= 1'b0;
        end else if (cnt != 5'(CNT_LAST)) begin
            cnt     <= cnt + 5'd1;
            cnt_end <= (cnt == 5'(CNT_LAST - 1)) && !no_end;
        end
    end

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] b, input logic d);
        return {b[63:0], b[127:64]} ^ {4{32'h9e37_79b9}} ^ {DATA_W{d}};
    endfunction

    // The datapath result is only meaningful while cnt_end is high.
    assign core_data = cnt_end ? exp_blk : {4{cyc}};

    initial begin : monitor
        bit start_prev = 1'b0;
        bit ov_prev    = 1'b0;
        bit err_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) begin
                    acc_q.push_back(cyc);
                    exp_blk = model(in_data, in_dec);
                    sb_q.push_back(exp_blk);
                end
                if (start) begin
                    start_cnt++;
                    if (!start_prev) last_gap = low_run;
                    low_run = 0;
                end else begin
                    low_run++;
                end
                if (load) begin
                    load_cnt++;
                    load_cnt_val = cnt;
                end
                if (round_en) rk_log.push_back(rk_idx);
                if (out_valid && !ov_prev) ov_q.push_back(cyc);
                if (out_valid && out_ready) obs_q.push_back(out_data);
                if (err && !err_prev) begin
                    err_seen = 1'b1;
                    err_cyc  = cyc;
                end
            end
            start_prev = start;
            ov_prev    = out_valid;
            err_prev   = err;
        end
    end

    task automatic clear_logs();
        start_cnt = 0;
        load_cnt  = 0;
        last_gap  = -1;
        err_seen  = 1'b0;
        rk_log.delete();
        ov_q.delete();
        acc_q.delete();
        obs_q.delete();
    endtask

    // Presents one block and returns at posedge+1 after it was taken (or after the bound).
    task automatic do_accept(input logic [DATA_W-1:0] d, input logic dec, output bit ok);
        in_data  = d;
        in_dec   = dec;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        no_end    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({start, load, round_en, out_valid, err, rk_idx} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {start, load, round_en, out_valid, err, rk_idx});
        end
        n_checks++;
        if ({blk_q, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got blk_q=%h out_data=%h want 0", blk_q, out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [DATA_W-1:0] d, input logic dec);
        bit ok;
        bit rk_ok;
        logic [4:0] want_rk;
        clear_logs();
        out_ready = 1'b1;
        do_accept(d, dec, ok);
        n_checks++;
        if (!ok || blk_q !== d || load !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: got taken=%0d blk_q=%h load=%b want blk_q=%h load=1", tag, ok, blk_q, load, d);
        end
        wait_obs(1, ok);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (start_cnt != 18 || load_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_start_load: got start=%0d load=%0d want 18 and 1", tag, start_cnt, load_cnt);
        end
        rk_ok = (rk_log.size() == 17);
        for (int i = 0; i < rk_log.size() && rk_ok; i++) begin
            want_rk = dec ? 5'(RK_LAST - i) : 5'(i);
            if (rk_log[i] !== want_rk) rk_ok = 1'b0;
        end
        n_checks++;
        if (!rk_ok) begin
            n_fail++;
            $display("FAIL %s_rk_seq: got %0d indices first=%0d want 17 starting at %0d", tag, rk_log.size(), (rk_log.size() > 0) ? rk_log[0] : 5'd31, dec ? RK_LAST : 0);
        end
        n_checks++;
        if (ov_q.size() != 1 || acc_q.size() != 1 || ov_q[0] - acc_q[0] != 32'd19) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d out_valid rises, latency %0d want 1 rise at 19", tag, ov_q.size(), (ov_q.size() > 0 && acc_q.size() > 0) ? ov_q[0] - acc_q[0] : 32'd0);
        end
        n_checks++;
        if (!ok || sb_q.size() == 0 || obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_out_data: got %0d results want 1", tag, obs_q.size());
        end else if (obs_q[0] !== sb_q[0]) begin
            n_fail++;
            $display("FAIL %s_out_data: got %h want %h", tag, obs_q[0], sb_q[0]);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_encrypt();
        run_single("enc", D_ENC, 1'b0);
    endtask

    task automatic test_decrypt();
        run_single("dec", D_DEC, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        logic [DATA_W-1:0] e, g;
        clear_logs();
        out_ready = 1'b1;
        do_accept(128'haaaa_5555_0000_ffff_1234_5678_9abc_def0, 1'b0, ok1);
        do_accept(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, ok2);
        wait_obs(2, ok3);
        n_checks++;
        if (!ok1 || !ok2 || acc_q.size() != 2 || acc_q[1] - acc_q[0] != 32'd19) begin
            n_fail++;
            $display("FAIL b2b_accept_gap: got %0d accepts gap %0d want 2 accepts gap 19", acc_q.size(), (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : 32'd0);
        end
        n_checks++;
        if (last_gap != 1 || load_cnt_val !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: got start low %0d cycles, cnt at load %0d want 1 and 0", last_gap, load_cnt_val);
        end
        n_checks++;
        if (ov_q.size() != 2 || acc_q.size() != 2 || ov_q[1] - acc_q[1] != 32'd19) begin
            n_fail++;
            $display("FAIL b2b_latency2: got %0d out_valid rises want 2 with second latency 19", ov_q.size());
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (sb_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_data%0d: missing result (expected %0d, observed %0d)", k, sb_q.size(), obs_q.size());
            end else begin
                e = sb_q.pop_front();
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h want %h", k, g, e);
                end
            end
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit ov_bad, data_bad, ir_bad, st_bad;
        clear_logs();
        out_ready = 1'b0;
        do_accept(128'hdead_beef_cafe_f00d_0bad_c0de_feed_face, 1'b0, ok);
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(negedge clk);
            #1;
        end
        ov_bad = 1'b0; data_bad = 1'b0; ir_bad = 1'b0; st_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1) ov_bad = 1'b1;
            if (sb_q.size() == 0 || out_data !== sb_q[0]) data_bad = 1'b1;
            if (in_ready !== 1'b0) ir_bad = 1'b1;
            if (start !== 1'b0) st_bad = 1'b1;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (ov_bad || data_bad) begin
            n_fail++;
            $display("FAIL bp_hold: got valid_drop=%0d data_change=%0d out_data=%h want both 0", ov_bad, data_bad, out_data);
        end
        n_checks++;
        if (ir_bad || st_bad) begin
            n_fail++;
            $display("FAIL bp_stall: got in_ready_high=%0d start_high=%0d want both 0", ir_bad, st_bad);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_obs(1, ok);
        n_checks++;
        if (!ok || sb_q.size() == 0 || obs_q.size() == 0 || obs_q[0] !== sb_q[0] || ov_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_release: got %0d results, %0d valid rises want exactly 1 matching result", obs_q.size(), ov_q.size());
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_watchdog();
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        no_end    = 1'b1;
        do_accept(128'h0000_1111_2222_3333_4444_5555_6666_7777, 1'b0, ok);
        for (int i = 0; i < 40 && !err_seen; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (err !== 1'b1 || acc_q.size() != 1 || err_cyc - acc_q[0] != 32'd25) begin
            n_fail++;
            $display("FAIL wd_trip: got err=%b at %0d cycles after accept want 1 at 25", err, (acc_q.size() > 0) ? err_cyc - acc_q[0] : 32'd0);
        end
        n_checks++;
        if (start_cnt != 24 || ov_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_abort: got start=%0d valid_rises=%0d in_ready=%b want 24, 0, 1", start_cnt, ov_q.size(), in_ready);
        end
        sb_q.delete();
        no_end = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        do_accept(128'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff, 1'b1, ok);
        wait_obs(1, ok);
        n_checks++;
        if (!ok || sb_q.size() == 0 || obs_q.size() == 0 || obs_q[0] !== sb_q[0] || err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_recover: got %0d results err=%b want 1 matching result with err=1", obs_q.size(), err);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        logic [31:0] rel_cyc;
        clear_logs();
        out_ready = 1'b1;
        do_accept(128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0, 1'b0, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt == 5'd9) break;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({start, load, round_en, out_valid, err, rk_idx} !== 10'd0 || {blk_q, out_data} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got ctrl=%b blk_q=%h out_data=%h want all 0", {start, load, round_en, out_valid, err, rk_idx}, blk_q, out_data);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        clear_logs();
        do_accept(128'hfeed_0001_feed_0002_feed_0003_feed_0004, 1'b1, ok);
        n_checks++;
        if (!ok || acc_q.size() != 1 || acc_q[0] != rel_cyc) begin
            n_fail++;
            $display("FAIL midrun_first_accept: got %0d accepts want one in the first cycle after release", acc_q.size());
        end
        wait_obs(1, ok);
        n_checks++;
        if (!ok || sb_q.size() == 0 || obs_q.size() == 0 || obs_q[0] !== sb_q[0] || ov_q.size() != 1 || ov_q[0] - acc_q[0] != 32'd19) begin
            n_fail++;
            $display("FAIL midrun_recover: got %0d results, %0d valid rises want 1 matching result at latency 19", obs_q.size(), ov_q.size());
        end
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_backpressure();
        test_watchdog();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
